j_latch_arb: RTL and testbench
==============================

J_LATCH_ARB -- requirements
Module: j_latch_arb

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the latch bank.
REQ-002 Parameter AW, default 3: latch-select address width; the bank holds 2**AW latches.
REQ-003 Parameter DW, default 16: data width of each latch.
REQ-004 sys_clk  input  1  the only clock; all state updates on its rising edge.
REQ-005 resetl  input  1  asynchronous, active-low reset.
REQ-006 req  input  NREQ  per-requester write request, level-held until ack.
REQ-007 req_addr  input  NREQ*AW  packed target latch index; requester i occupies bits [i*AW +: AW].
REQ-008 req_data  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
REQ-009 ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 lat_d  output  DW  data bus to the d input of every latch in the bank.
REQ-011 lat_en  output  2**AW  one-hot load enables to the bank latches.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 All outputs SHALL be registered; none SHALL depend combinationally on req, req_addr or req_data.
REQ-014 The FSM SHALL have four states, IDLE -> SETUP -> STROBE -> ACK -> IDLE, with no other transitions.
REQ-015 IDLE: if any eligible req bit is high at a rising edge, the FSM SHALL select one requester g, capture its addr and data, and move to SETUP; otherwise it SHALL stay in IDLE.
REQ-016 Selection SHALL be round-robin: search starts at (last+1) mod NREQ and ascends with wrap; last resets to NREQ-1, so requester 0 wins first.
REQ-017 SETUP: lat_d SHALL carry the captured data; lat_en SHALL be all zero (one-cycle data settle).
REQ-018 STROBE: lat_d SHALL hold the captured data; lat_en SHALL be one-hot at the captured address for exactly one cycle.
REQ-019 ACK: lat_en SHALL be zero; lat_d SHALL hold its value; ack[g] SHALL be high for exactly one cycle; last SHALL update to g.
REQ-020 lat_d SHALL hold its last value in IDLE; it SHALL change only on entry to SETUP.
REQ-021 Latency: if req is sampled at edge n in IDLE, SETUP is cycle n+1, STROBE is n+2 and ACK is n+3; throughput is one write per 4 cycles.
REQ-022 In the single IDLE cycle after ACK, the just-acked requester SHALL be ineligible; the requester deasserts req on seeing ack.
REQ-023 Once captured, a transaction SHALL complete even if req[g] drops, or req_addr/req_data change, before ACK.
REQ-024 Requests arriving while busy SHALL be held off with no ack and no loss; they are arbitrated at the next eligible IDLE sample.
REQ-025 At most one lat_en bit and at most one ack bit SHALL be high in any cycle.

Reset
REQ-026 resetl low SHALL immediately force: state=IDLE, lat_en=0, ack=0, lat_d=0, busy=0, last=NREQ-1, captured addr/data=0.
REQ-027 Reset mid-transaction SHALL abandon the write with no lat_en pulse and no ack; the first arbitration after release starts from requester 0.
REQ-028 After resetl rises, the first IDLE sample SHALL occur on the first following rising edge.

Verification
REQ-029 Single write: req=001, addr0=5, data0=0xBEEF at edge n -> lat_d=0xBEEF from n+1; lat_en=0x20 only at n+2; ack=001 only at n+3.
REQ-030 Contention: req=111 held, each requester dropping req on its ack -> acks in order 001, 010, 100, 4 cycles apart; lat_en never multi-hot.
REQ-031 Fairness: req=011 with requester 0 re-requesting immediately after each ack -> grants alternate 0,1,0,1; no requester is starved.
REQ-032 Early drop: req=010, addr1=2, data1=0x1234 held one cycle only -> full sequence still completes with lat_en=0x04 and ack=010.
REQ-033 Reset in STROBE: resetl low during the lat_en pulse -> lat_en=0 and ack=0 at once, no ack follows; after release with req=110, requester 1 wins first.
REQ-034 Idle hold: no requests for 20 cycles after a write of 0xA5A5 -> lat_d stays 0xA5A5, busy=0, lat_en=0 throughout.

Source files
------------

// File: rtl/j_latch_arb.sv
// Round-robin arbiter that serialises requester writes into a bank of
// transparent latches with a setup / strobe / ack handshake.
module j_latch_arb #(
    parameter int NREQ = 3,
    parameter int AW   = 3,
    parameter int DW   = 16
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic [DW-1:0]        lat_d,
    output logic [(1<<AW)-1:0]   lat_en,
    output logic                 busy
);

    localparam int NL = 1 << AW;
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_ACK
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [GW-1:0]   last;
    logic [GW-1:0]   cap_g;
    logic [GW-1:0]   sel;
    logic [AW-1:0]   cap_addr;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREQ-1:0] excl;
    logic [NREQ-1:0] elig;
    logic            found;
    int              idx;

    // excl masks the requester acked one cycle ago while it drops req
    always_comb begin
        elig  = req & ~excl;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
        sel_addr = req_addr[int'(sel)*AW +: AW];
        sel_data = req_data[int'(sel)*DW +: DW];
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (found) state_nx = S_SETUP;
            S_SETUP:  state_nx = S_STROBE;
            S_STROBE: state_nx = S_ACK;
            S_ACK:    state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) state <= S_IDLE;
        else         state <= state_nx;
    end

    // lat_d doubles as the captured write data
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            last     <= GW'(NREQ - 1);
            cap_g    <= '0;
            cap_addr <= '0;
            lat_d    <= '0;
            lat_en   <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            excl     <= '0;
        end else begin
            busy   <= (state_nx != S_IDLE);
            lat_en <= '0;
            ack    <= '0;
            excl   <= '0;
            unique case (state)
                S_IDLE: begin
                    if (found) begin
                        cap_g    <= sel;
                        cap_addr <= sel_addr;
                        lat_d    <= sel_data;
                    end
                end
                S_SETUP: lat_en <= NL'(1) << cap_addr;
                S_STROBE: begin
                    ack  <= NREQ'(1) << cap_g;
                    last <= cap_g;
                end
                S_ACK:   excl <= NREQ'(1) << cap_g;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_j_latch_arb.sv
// Bench for j_latch_arb: transaction model feeds a scoreboard queue,
// a negedge monitor consumes it; directed scenarios then random traffic.
module tb_j_latch_arb;

    localparam int NREQ = 3;
    localparam int AW   = 3;
    localparam int DW   = 16;
    localparam int NL   = 1 << AW;

    logic                clk = 1'b0;
    logic                resetl = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*AW-1:0]  req_addr = '0;
    logic [NREQ*DW-1:0]  req_data = '0;
    logic [NREQ-1:0]     ack;
    logic [DW-1:0]       lat_d;
    logic [NL-1:0]       lat_en;
    logic                busy;

    always #5 clk = ~clk;

    j_latch_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .sys_clk  (clk),
        .resetl   (resetl),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .lat_d    (lat_d),
        .lat_en   (lat_en),
        .busy     (busy)
    );

    typedef struct {
        int g;
        int addr;
        int data;
        int n;
    } exp_t;

    typedef struct {
        logic [NREQ-1:0] a;
        logic [NL-1:0]   en;
        logic [DW-1:0]   d;
        int              c;
    } log_t;

    exp_t            q[$];
    log_t            lg[$];
    int              rd = 0;
    int              cyc = 0;
    int              total = 0;
    int              bad = 0;
    logic [DW-1:0]   m_latd = '0;
    logic [NL-1:0]   st_en = '0;
    logic [NREQ-1:0] rereq = '0;
    bit              rnd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    // Transaction model: a granted write occupies four cycles, round-robin
    // from the last winner, the just-finished winner sits out one sample.
    initial begin : model
        int m_cnt;
        int m_last;
        int m_excl;
        int g;
        int i;
        m_cnt  = 0;
        m_last = NREQ - 1;
        m_excl = -1;
        forever begin
            @(posedge clk);
            cyc++;
            if (!resetl) begin
                m_cnt  = 0;
                m_last = NREQ - 1;
                m_excl = -1;
                m_latd = '0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_excl = m_last;
            end else begin
                g = -1;
                for (int k = 1; k <= NREQ; k++) begin
                    i = (m_last + k) % NREQ;
                    if (g < 0 && req[i] && i != m_excl) g = i;
                end
                m_excl = -1;
                if (g >= 0) begin
                    m_cnt  = 3;
                    m_last = g;
                    m_latd = req_data[g*DW +: DW];
                    q.push_back('{g, int'(req_addr[g*AW +: AW]),
                                  int'(req_data[g*DW +: DW]), cyc});
                end
            end
        end
    end

    task automatic mon();
        exp_t e;
        int   k;
        if (!resetl) begin
            chk("rst_ack", ack, 0);
            chk("rst_en", lat_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_d", lat_d, 0);
            rd = q.size();
            return;
        end
        chk("en_onehot", $countones(lat_en) <= 1, 1);
        chk("ack_onehot", $countones(ack) <= 1, 1);
        if (rd < q.size()) begin
            e = q[rd];
            k = cyc - e.n;
            chk("busy", busy, 1);
            chk("lat_d", lat_d, e.data);
            case (k)
                0: begin
                    chk("setup_en", lat_en, 0);
                    chk("setup_ack", ack, 0);
                end
                1: begin
                    chk("strobe_en", lat_en, 1 << e.addr);
                    chk("strobe_ack", ack, 0);
                    st_en = lat_en;
                end
                2: begin
                    chk("ack_en", lat_en, 0);
                    chk("ack", ack, 1 << e.g);
                    lg.push_back('{ack, st_en, lat_d, cyc});
                    rd++;
                end
                default: begin
                    chk("phase", k, 2);
                    rd++;
                end
            endcase
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_en", lat_en, 0);
            chk("idle_ack", ack, 0);
            chk("idle_d", lat_d, m_latd);
        end
    endtask

    task automatic rand_drive();
        int r;
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) begin
                if ($urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW] = AW'($urandom);
                    req_data[i*DW +: DW] = DW'($urandom);
                end
            end else begin
                r = $urandom_range(15);
                if (r == 0) req[i] = 1'b0;
                else if (r == 1) req_data[i*DW +: DW] = DW'($urandom);
                else if (r == 2) req_addr[i*AW +: AW] = AW'($urandom);
            end
        end
        if (!resetl) resetl = 1'b1;
        else if ($urandom_range(299) == 0) resetl = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                if (rereq[i]) req_data[i*DW +: DW] += 1;
                else req[i] = 1'b0;
            end
        end
        if (rnd) rand_drive();
    endtask

    task automatic wait_log(input int n, input int budget, input string nm);
        for (int b = 0; b < budget && lg.size() < n; b++) step();
        chk(nm, lg.size() >= n, 1);
    endtask

    task automatic chk_log(input int idx, input string nm,
                           input logic [NREQ-1:0] a, input logic [NL-1:0] en);
        if (lg.size() > idx) begin
            chk({nm, "_ack"}, lg[idx].a, a);
            chk({nm, "_en"}, lg[idx].en, en);
        end
    endtask

    task automatic do_reset();
        resetl = 1'b0;
        req = '0;
        step();
        step();
        resetl = 1'b1;
    endtask

    task automatic set_req(input int i, input int a, input int d);
        req[i] = 1'b1;
        req_addr[i*AW +: AW] = AW'(a);
        req_data[i*DW +: DW] = DW'(d);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c0;
        bit seen;
        #2 resetl = 1'b0;
        #1;
        chk("por_en", lat_en, 0);
        chk("por_ack", ack, 0);
        chk("por_busy", busy, 0);
        chk("por_d", lat_d, 0);
        step();
        step();
        resetl = 1'b1;

        // single write
        lg.delete();
        c0 = cyc;
        set_req(0, 5, 16'hBEEF);
        wait_log(1, 20, "single_to");
        chk_log(0, "single", 3'b001, 8'h20);
        if (lg.size() > 0) begin
            chk("single_d", lg[0].d, 16'hBEEF);
            chk("single_lat", lg[0].c - c0, 3);
        end

        // idle hold
        repeat (3) step();
        lg.delete();
        set_req(0, 1, 16'hA5A5);
        wait_log(1, 20, "hold_to");
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hold_d", lat_d, 16'hA5A5);
            chk("hold_busy", busy, 0);
            chk("hold_en", lat_en, 0);
        end

        // contention
        do_reset();
        lg.delete();
        set_req(0, 1, 16'h1111);
        set_req(1, 3, 16'h2222);
        set_req(2, 7, 16'h3333);
        wait_log(3, 40, "cont_to");
        chk_log(0, "cont0", 3'b001, 8'h02);
        chk_log(1, "cont1", 3'b010, 8'h08);
        chk_log(2, "cont2", 3'b100, 8'h80);
        if (lg.size() > 2) begin
            chk("cont_gap1", lg[1].c - lg[0].c, 4);
            chk("cont_gap2", lg[2].c - lg[1].c, 4);
        end

        // fairness
        do_reset();
        lg.delete();
        rereq = 3'b011;
        set_req(0, 2, 16'h0100);
        set_req(1, 6, 16'h0200);
        wait_log(4, 40, "fair_to");
        rereq = '0;
        req = '0;
        chk_log(0, "fair0", 3'b001, 8'h04);
        chk_log(1, "fair1", 3'b010, 8'h40);
        chk_log(2, "fair2", 3'b001, 8'h04);
        chk_log(3, "fair3", 3'b010, 8'h40);

        // early drop
        repeat (3) step();
        lg.delete();
        set_req(1, 2, 16'h1234);
        step();
        req = '0;
        req_data = '1;
        req_addr = '1;
        wait_log(1, 20, "drop_to");
        chk_log(0, "drop", 3'b010, 8'h04);
        if (lg.size() > 0) chk("drop_d", lg[0].d, 16'h1234);

        // reset during the strobe
        do_reset();
        set_req(0, 4, 16'h0F0F);
        seen = 1'b0;
        for (int b = 0; b < 10 && !seen; b++) begin
            step();
            seen = (lat_en != 0);
        end
        chk("strobe_seen", seen, 1);
        resetl = 1'b0;
        req = '0;
        set_req(1, 6, 16'h6666);
        set_req(2, 0, 16'h7777);
        #1;
        chk("rst_mid_en", lat_en, 0);
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_busy", busy, 0);
        lg.delete();
        step();
        step();
        resetl = 1'b1;
        wait_log(1, 20, "rst_to");
        chk_log(0, "rst_first", 3'b010, 8'h40);
        req = '0;
        repeat (8) step();

        // random traffic
        rnd = 1'b1;
        repeat (600) step();
        rnd = 1'b0;
        resetl = 1'b1;
        req = '0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
